stack_arbiter: RTL and testbench
================================

STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 Parameter W, default 4, data width of stack entries.
REQ-002 Parameter DEPTH, default 32, stack capacity in entries.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous reset, active low.
REQ-006 req  in  2  per-requester request; held until the matching gnt.
REQ-007 op  in  2  per-requester operation: 1 = push, 0 = pop.
REQ-008 din0, din1  in  W  per-requester push data.
REQ-009 flush  in  1  clear stack request; held until serviced.
REQ-010 gnt  out  2  one-hot grant, asserted one cycle.
REQ-011 done  out  2  one-hot completion pulse to the granted requester.
REQ-012 err  out  1  valid with done: 1 = operation rejected (overflow or underflow).
REQ-013 dout  out  W  pop result, valid with done on a successful pop.
REQ-014 full, empty  out  1  occupancy flags derived from the internal count.
REQ-015 s_push, s_pop, s_clr  out  1  stack controls; s_clr drives the stack's synchronous active-high clear.
REQ-016 s_din  out  W  stack push data.
REQ-017 s_dout  in  W  stack registered pop data, valid the cycle after s_pop.

Function
REQ-018 FSM states: INIT, IDLE, ISSUE, CAPT, RESP.
- INIT: assert s_clr for one cycle, then go to IDLE.
REQ-019 IDLE with flush=1 SHALL take priority over requests.
- Assert s_clr for one cycle, set count to 0, stay in IDLE.
REQ-020 IDLE arbitration SHALL be round-robin between req[0] and req[1].
- With both requesting, the requester not granted last wins.
REQ-021 In the arbitration cycle, gnt[i] is combinational and high; the block latches i, op[i] and din_i.
REQ-022 Latched push with count==DEPTH, or pop with count==0, SHALL go IDLE->RESP with err=1.
- No stack control is asserted and count is unchanged.
REQ-023 Valid push: IDLE->ISSUE->RESP.
- ISSUE asserts s_push with s_din = latched data; count increments.
REQ-024 Valid pop: IDLE->ISSUE->CAPT->RESP.
- ISSUE asserts s_pop; count decrements.
- CAPT registers s_dout into dout.
REQ-025 RESP asserts done[i] for exactly one cycle (err per REQ-022), then returns to IDLE.
- Requests are not arbitrated in RESP.
REQ-026 Latency from gnt cycle G: push done at G+2, pop done at G+3, rejected done at G+1.
REQ-027 s_push and s_pop SHALL never be high together and SHALL each last exactly one cycle.
REQ-028 full = (count==DEPTH); empty = (count==0).
- count is clog2(DEPTH)+1 bits wide and never wraps.
REQ-029 flush asserted outside IDLE SHALL wait and be serviced at the next IDLE.
REQ-030 dout SHALL hold its last value until the next successful pop.

Reset
REQ-031 rst low SHALL immediately force the following, even mid-operation:
- state = INIT, count = 0.
- gnt, done, err, s_push, s_pop = 0; dout = 0.
- last-grant = 1, so requester 0 wins the first tie.
REQ-032 The first cycle after rst releases SHALL be INIT, clearing the stack.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding and the op encoding constants (OP_PUSH, OP_POP).
REQ-034 The round-robin 2-way arbiter SHALL be a sub-module named rr_arb2, with inputs req and last and output one-hot gnt.
REQ-035 The stack itself is instantiated outside this block; only its ports are driven.

Verification
REQ-036 After reset release: s_clr high for 1 cycle, then empty=1, full=0.
REQ-037 req=01, op0=1, din0=4'hA, then req=01, op0=0:
- gnt0, then done0 at G+2 with err=0.
- Pop: done0 at G+3, dout=4'hA, err=0; count 1->0.
REQ-038 req=11 held, op=11, din0=1, din1=2:
- Grants alternate 0,1,0,1.
- Subsequent pops return the pushed values in LIFO order.
REQ-039 Push 32 entries: full=1.
- 33rd push: done with err=1, no s_push, count stays 32.
- Pop from empty: err=1, no s_pop.
REQ-040 flush asserted during a pop's CAPT state:
- The pop completes with correct dout.
- Then s_clr for 1 cycle and empty=1.
REQ-041 rst low during ISSUE of a push: all outputs 0 at once; INIT follows release; count=0.

Source files
------------

// File: rtl/stack_arbiter_pkg.sv
// Shared encodings for the two-requester stack arbiter: FSM states and op codes.
package stack_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_CAPT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

endpackage

// File: rtl/stack_arbiter_if.sv
// Requester-side bus of the stack arbiter: per-requester handshakes, data and flags.
interface stack_arbiter_if #(
  parameter int W = 4
) ();

  logic [1:0]   req;
  logic [1:0]   op;
  logic [W-1:0] din0;
  logic [W-1:0] din1;
  logic         flush;
  logic [1:0]   gnt;
  logic [1:0]   done;
  logic         err;
  logic [W-1:0] dout;
  logic         full;
  logic         empty;

  modport master (
    output req, op, din0, din1, flush,
    input  gnt, done, err, dout, full, empty
  );

  modport slave (
    input  req, op, din0, din1, flush,
    output gnt, done, err, dout, full, empty
  );

endinterface

// File: rtl/stack_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[0] && req[1]) begin
      gnt = last ? 2'b01 : 2'b10;
    end else if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Arbitrates two requesters onto one external stack, tracks occupancy and
// returns per-requester completion, error and pop data.
module stack_arbiter
  import stack_arbiter_pkg::*;
#(
  parameter int W     = 4,
  parameter int DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  stack_arbiter_if.slave       bus,
  output logic                 s_push,
  output logic                 s_pop,
  output logic                 s_clr,
  output logic [W-1:0]         s_din,
  input  logic [W-1:0]         s_dout
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t         state_reg, state_next;
  logic [CW-1:0]  count_reg;
  logic           last_reg;
  logic           sel_reg;
  logic           op_reg;
  logic           err_reg;
  logic [W-1:0]   data_reg;
  logic [W-1:0]   dout_reg;

  logic [1:0]     arb_gnt;
  logic           arb_fire;
  logic           win;
  logic           win_op;
  logic [W-1:0]   win_data;
  logic           reject;

  rr_arb2 u_arb (
    .req  (bus.req),
    .last (last_reg),
    .gnt  (arb_gnt)
  );

  // Flush outranks requests, so a grant only happens in a flush-free IDLE cycle.
  assign arb_fire = (state_reg == ST_IDLE) && !bus.flush && (arb_gnt != 2'b00);
  assign win      = arb_gnt[1];
  assign win_op   = bus.op[win];
  assign win_data = win ? bus.din1 : bus.din0;
  assign reject   = (win_op == OP_PUSH) ? (count_reg == CW'(DEPTH)) : (count_reg == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_INIT:  state_next = ST_IDLE;
      ST_IDLE:  if (arb_fire) state_next = reject ? ST_RESP : ST_ISSUE;
      ST_ISSUE: state_next = (op_reg == OP_PUSH) ? ST_RESP : ST_CAPT;
      ST_CAPT:  state_next = ST_RESP;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_INIT;
    endcase
  end

  always_comb begin
    bus.gnt = arb_fire ? arb_gnt : 2'b00;
    s_clr   = (state_reg == ST_INIT) || ((state_reg == ST_IDLE) && bus.flush);
    s_push  = (state_reg == ST_ISSUE) && (op_reg == OP_PUSH);
    s_pop   = (state_reg == ST_ISSUE) && (op_reg == OP_POP);
    s_din   = data_reg;
    bus.err = (state_reg == ST_RESP) && err_reg;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_done
    assign bus.done[gi] = (state_reg == ST_RESP) && (sel_reg == 1'(gi));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
      last_reg  <= 1'b1;
      sel_reg   <= 1'b0;
      op_reg    <= OP_POP;
      err_reg   <= 1'b0;
      data_reg  <= '0;
      dout_reg  <= '0;
    end else begin
      if ((state_reg == ST_INIT) || ((state_reg == ST_IDLE) && bus.flush)) begin
        count_reg <= '0;
      end
      if (arb_fire) begin
        last_reg <= win;
        sel_reg  <= win;
        op_reg   <= win_op;
        data_reg <= win_data;
        err_reg  <= reject;
      end
      if (state_reg == ST_ISSUE) begin
        count_reg <= (op_reg == OP_PUSH) ? count_reg + 1'b1 : count_reg - 1'b1;
      end
      // Stack read data is registered, so it is valid one cycle after s_pop.
      if (state_reg == ST_CAPT) begin
        dout_reg <= s_dout;
      end
    end
  end

  assign bus.dout  = dout_reg;
  assign bus.full  = (count_reg == CW'(DEPTH));
  assign bus.empty = (count_reg == '0);

endmodule

// File: tb/tb_stack_arbiter.sv
// Randomized bench for stack_arbiter: an emulated external stack plus a
// queue-based reference model of the arbitration and stack semantics.
module tb_stack_arbiter;
  import stack_arbiter_pkg::*;

  localparam int W     = 4;
  localparam int DEPTH = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         s_push, s_pop, s_clr;
  logic [W-1:0] s_din;
  logic [W-1:0] s_dout = '0;

  stack_arbiter_if #(.W(W)) bus ();

  stack_arbiter #(.W(W), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .s_push (s_push),
    .s_pop  (s_pop),
    .s_clr  (s_clr),
    .s_din  (s_din),
    .s_dout (s_dout)
  );

  always #5 clk = ~clk;

  // External stack with registered pop data.
  logic [W-1:0] stk_mem [DEPTH];
  int           stk_sp = 0;
  always @(posedge clk) begin
    if (s_clr) begin
      stk_sp <= 0;
    end else if (s_push && stk_sp < DEPTH) begin
      stk_mem[stk_sp] <= s_din;
      stk_sp <= stk_sp + 1;
    end else if (s_pop && stk_sp > 0) begin
      s_dout <= stk_mem[stk_sp - 1];
      stk_sp <= stk_sp - 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [W-1:0] m_stack [$];
  bit           m_last = 1'b1;
  logic [W-1:0] m_dout = '0;

  // Requester state (held until granted)
  bit   [1:0]   rq  = 2'b00;
  bit   [1:0]   rop = 2'b00;
  logic [W-1:0] rd [2];

  task automatic drive_bus();
    bus.req  = rq;
    bus.op   = rop;
    bus.din0 = rd[0];
    bus.din1 = rd[1];
  endtask

  task automatic wait_gnt(output bit ok);
    int cyc;
    cyc = 0;
    ok  = 1'b0;
    while (!ok && cyc < 6) begin
      if (bus.flush) begin
        chk("flush_blocks_gnt", bus.gnt, 2'b00);
        chk("flush_clr", s_clr, 1'b1);
        m_stack.delete();
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        chk("flush_empty", bus.empty, 1'b1);
      end else if (bus.gnt != 2'b00) begin
        ok = 1'b1;
      end else begin
        @(negedge clk);
        #1;
      end
      cyc++;
    end
    if (!ok) chk("gnt_timeout", 1'b0, 1'b1);
  endtask

  task automatic run_txn(input int push_pct, input int flush_pct, input bit allow_new);
    bit           ok, e_op, exp_err, got_done, prev_pop;
    int           exp_w, act_w, exp_lat, lat, n_push, n_pop;
    logic [W-1:0] e_data;
    @(negedge clk);
    if (allow_new) begin
      for (int i = 0; i < 2; i++) begin
        if (!rq[i] && $urandom_range(0, 1) == 1) begin
          rq[i]  = 1'b1;
          rop[i] = ($urandom_range(1, 100) <= push_pct);
          rd[i]  = W'($urandom);
        end
      end
    end
    if (rq == 2'b00) begin
      rq[0]  = 1'b1;
      rop[0] = ($urandom_range(1, 100) <= push_pct);
      rd[0]  = W'($urandom);
    end
    if (!bus.flush && $urandom_range(1, 100) <= flush_pct) bus.flush = 1'b1;
    drive_bus();
    #1;
    chk("done_one_cycle", bus.done, 2'b00);
    wait_gnt(ok);
    if (!ok) return;
    chk("clr_at_gnt", s_clr, 1'b0);

    exp_w   = (rq == 2'b11) ? (m_last ? 0 : 1) : (rq[1] ? 1 : 0);
    act_w   = bus.gnt[1] ? 1 : 0;
    chk("gnt", bus.gnt, (exp_w == 1) ? 2'b10 : 2'b01);
    m_last  = exp_w[0];
    e_op    = rop[exp_w];
    e_data  = rd[exp_w];
    exp_err = (e_op == OP_PUSH) ? (m_stack.size() == DEPTH) : (m_stack.size() == 0);
    exp_lat = exp_err ? 1 : ((e_op == OP_PUSH) ? 2 : 3);

    n_push = 0; n_pop = 0; lat = 0; got_done = 1'b0; prev_pop = 1'b0;
    while (!got_done && lat < 6) begin
      @(negedge clk);
      if (lat == 0) begin
        rq[act_w] = 1'b0;
        drive_bus();
      end
      // prev_pop means this cycle is the capture cycle
      if (prev_pop && !bus.flush && $urandom_range(1, 100) <= 4 * flush_pct) bus.flush = 1'b1;
      #1;
      lat++;
      if (s_push) begin
        n_push++;
        chk("s_din", s_din, e_data);
      end
      if (s_pop) n_pop++;
      chk("push_pop_excl", s_push & s_pop, 1'b0);
      chk("busy_no_clr", s_clr, 1'b0);
      chk("busy_no_gnt", bus.gnt, 2'b00);
      prev_pop = s_pop;
      if (bus.done != 2'b00) got_done = 1'b1;
    end

    if (!exp_err) begin
      if (e_op == OP_PUSH) m_stack.push_back(e_data);
      else m_dout = m_stack.pop_back();
    end
    chk("done", bus.done, (exp_w == 1) ? 2'b10 : 2'b01);
    chk("latency", lat, exp_lat);
    chk("err", bus.err, exp_err);
    chk("s_push_count", n_push, (!exp_err && e_op == OP_PUSH) ? 1 : 0);
    chk("s_pop_count", n_pop, (!exp_err && e_op == OP_POP) ? 1 : 0);
    chk("dout", bus.dout, m_dout);
    chk("empty", bus.empty, m_stack.size() == 0);
    chk("full", bus.full, m_stack.size() == DEPTH);
    $display("[TB] txn req%0d %s data=%0h err=%0d lat=%0d dout=%0h depth=%0d",
             exp_w, (e_op == OP_PUSH) ? "push" : "pop", e_data, exp_err, lat,
             bus.dout, m_stack.size());
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"},    bus.gnt,   2'b00);
    chk({tag, "_done"},   bus.done,  2'b00);
    chk({tag, "_err"},    bus.err,   1'b0);
    chk({tag, "_s_push"}, s_push,    1'b0);
    chk({tag, "_s_pop"},  s_pop,     1'b0);
    chk({tag, "_dout"},   bus.dout,  '0);
    chk({tag, "_empty"},  bus.empty, 1'b1);
    chk({tag, "_full"},   bus.full,  1'b0);
  endtask

  task automatic release_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk({tag, "_init_clr"}, s_clr, 1'b1);
    @(negedge clk);
    #1;
    chk({tag, "_clr_one_cycle"}, s_clr, 1'b0);
    chk({tag, "_empty"}, bus.empty, 1'b1);
    chk({tag, "_full"},  bus.full,  1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rd[0] = '0;
    rd[1] = '0;
    bus.flush = 1'b0;
    drive_bus();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("por");
    release_reset("por");

    // Fill past capacity, mixed traffic with flushes, then drain past empty.
    for (int t = 0; t < 45; t++) run_txn(100, 0, 1'b1);
    for (int t = 0; t < 80; t++) run_txn(50, 10, 1'b1);
    for (int t = 0; t < 45; t++) run_txn(0, 0, 1'b1);
    do run_txn(50, 0, 1'b0); while (rq != 2'b00);

    // Reset in the middle of an issued operation.
    @(negedge clk);
    rq     = 2'b01;
    rop[0] = (m_stack.size() < DEPTH);
    rd[0]  = 4'h5;
    drive_bus();
    #1;
    chk("mid_gnt", bus.gnt, 2'b01);
    @(negedge clk);
    rq = 2'b00;
    drive_bus();
    #1;
    chk("mid_issue", s_push | s_pop, 1'b1);
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    m_stack.delete();
    m_last = 1'b1;
    m_dout = '0;
    release_reset("mid_rst");

    // Tie after reset goes to requester 0, then requester 1.
    rq = 2'b11; rop = 2'b11; rd[0] = 4'h1; rd[1] = 4'h2;
    run_txn(100, 0, 1'b0);
    run_txn(100, 0, 1'b0);
    rq = 2'b11; rop = 2'b00;
    run_txn(0, 0, 1'b0);
    run_txn(0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
